// File: rtl/full_spi_if.sv
// Bus bundle for the full_spi master: user-side byte handshake plus the SPI pins.
interface full_spi_if;
    logic       SPI_Enable;
    logic [7:0] OutputData;
    logic       SPI_MISO;
    logic       SPI_MOSI;
    logic       SPI_CLK;
    logic [7:0] InputData;
    logic       DataClk;

    // The SPI master block itself.
    modport master (
        input  SPI_Enable,
        input  OutputData,
        input  SPI_MISO,
        output SPI_MOSI,
        output SPI_CLK,
        output InputData,
        output DataClk
    );

    // User logic / attached slave environment.
    modport slave (
        output SPI_Enable,
        output OutputData,
        output SPI_MISO,
        input  SPI_MOSI,
        input  SPI_CLK,
        input  InputData,
        input  DataClk
    );
endinterface

// File: rtl/full_spi.sv
// Free-running SPI master (mode 0): 16 input clocks per 8-bit frame, byte-rate DataClk strobe.
// Enable and the transmit byte are sampled only at frame boundaries, so frames are never partial.
module full_spi #(
    parameter logic IDLE_MOSI = 1'b1
) (
    input logic         SPI_InputCLK,
    input logic         Reset,
    full_spi_if.master  bus
);

    logic [3:0] p_q, p_d;
    logic       frame_en_q, frame_en_d;
    logic [7:0] tx_q, tx_d;
    logic [7:0] rx_q, rx_d;
    logic [7:0] in_data_q, in_data_d;
    logic       dclk_q, dclk_d;
    logic       sck_q, sck_d;
    logic       mosi_q, mosi_d;
    logic       wrap;
    logic [2:0] bit_idx;

    // Next-state logic: everything is expressed in terms of the phase being entered (p_d).
    always_comb begin
        p_d        = p_q + 4'd1;
        wrap       = (p_q == 4'hF);
        frame_en_d = frame_en_q;
        tx_d       = tx_q;
        rx_d       = rx_q;
        in_data_d  = in_data_q;
        dclk_d     = dclk_q;

        if (wrap) begin
            frame_en_d = bus.SPI_Enable;
            tx_d       = bus.OutputData;
            // Publish the byte gathered in the frame that is ending; idle frames read as all-ones.
            in_data_d  = frame_en_q ? rx_q : 8'hFF;
            dclk_d     = 1'b1;
        end else if (p_q == 4'd7) begin
            dclk_d     = 1'b0;
        end

        // Sample MISO on the SCK rising edge, i.e. when entering an odd phase.
        if (frame_en_q && p_d[0]) begin
            rx_d = {rx_q[6:0], bus.SPI_MISO};
        end

        // Bit b of the frame spans phases 2b/2b+1 and carries tx[7-b].
        bit_idx = 3'd7 - p_d[3:1];
        sck_d   = frame_en_d & p_d[0];
        mosi_d  = frame_en_d ? tx_d[bit_idx] : IDLE_MOSI;
    end

    // State register with synchronous, active-high reset that overrides a frame in progress.
    always_ff @(posedge SPI_InputCLK) begin
        if (Reset) begin
            p_q        <= 4'd0;
            frame_en_q <= 1'b0;
            tx_q       <= 8'hFF;
            rx_q       <= 8'hFF;
            in_data_q  <= 8'hFF;
            dclk_q     <= 1'b0;
            sck_q      <= 1'b0;
            mosi_q     <= IDLE_MOSI;
        end else begin
            p_q        <= p_d;
            frame_en_q <= frame_en_d;
            tx_q       <= tx_d;
            rx_q       <= rx_d;
            in_data_q  <= in_data_d;
            dclk_q     <= dclk_d;
            sck_q      <= sck_d;
            mosi_q     <= mosi_d;
        end
    end

    // All outputs come straight from registers.
    always_comb begin
        bus.SPI_MOSI  = mosi_q;
        bus.SPI_CLK   = sck_q;
        bus.InputData = in_data_q;
        bus.DataClk   = dclk_q;
    end

endmodule

// File: tb/tb_full_spi.sv
// Self-checking bench for full_spi: scoreboards hold the expected MOSI bit at each SCK rise
// and the expected InputData at each DataClk rise.
module tb_full_spi;

    logic clk;
    logic rst;
    full_spi_if bus ();

    full_spi #(.IDLE_MOSI(1'b1)) dut (
        .SPI_InputCLK (clk),
        .Reset        (rst),
        .bus          (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int edge_cnt = 0;
    int sck_pulses = 0;
    logic prev_sck = 1'b0;
    logic prev_dclk = 1'b0;
    logic prev_mosi = 1'b1;

    logic mosi_sb[$];
    logic [7:0] rx_sb[$];

    // Properties of the frame currently on the wire (latched at the last boundary).
    logic       cur_en = 1'b0;
    logic [7:0] cur_tx = 8'hFF;
    logic [7:0] cur_slave = 8'h00;
    bit         cur_loop = 1'b0;

    // Advance one clock, sample on the falling edge and check against the scoreboards.
    task automatic step();
        logic exp_d;
        logic exp_b;
        logic [7:0] exp_rx;
        @(negedge clk);
        edge_cnt++;
        exp_d = (edge_cnt >= 16) && ((edge_cnt % 16) < 8);
        checks++;
        if (bus.DataClk !== exp_d) begin
            errors++;
            $display("FAIL dataclk_wave edge=%0d got=%b exp=%b", edge_cnt, bus.DataClk, exp_d);
        end
        if (bus.SPI_CLK === 1'b1 && prev_sck === 1'b0) begin
            sck_pulses++;
            checks++;
            if (mosi_sb.size() == 0) begin
                errors++;
                $display("FAIL sck_unexpected edge=%0d got=pulse exp=none", edge_cnt);
            end else begin
                exp_b = mosi_sb.pop_front();
                if (bus.SPI_MOSI !== exp_b || prev_mosi !== exp_b) begin
                    errors++;
                    $display("FAIL mosi_bit edge=%0d got=%b(before rise %b) exp=%b",
                             edge_cnt, bus.SPI_MOSI, prev_mosi, exp_b);
                end
            end
        end
        if (bus.DataClk === 1'b1 && prev_dclk === 1'b0) begin
            checks++;
            if (rx_sb.size() == 0) begin
                errors++;
                $display("FAIL rx_unexpected edge=%0d got=%h exp=none", edge_cnt, bus.InputData);
            end else begin
                exp_rx = rx_sb.pop_front();
                if (bus.InputData !== exp_rx) begin
                    errors++;
                    $display("FAIL input_data edge=%0d got=%h exp=%h", edge_cnt, bus.InputData,
                             exp_rx);
                end
            end
        end
        prev_sck  = bus.SPI_CLK;
        prev_dclk = bus.DataClk;
        prev_mosi = bus.SPI_MOSI;
    endtask

    // Slave side: present bit for the even phase just entered (changes while SCK is low).
    task automatic drive_miso(input int ph);
        if (!cur_en) bus.SPI_MISO = 1'($urandom_range(0, 1));
        else if (cur_loop) bus.SPI_MISO = bus.SPI_MOSI;
        else bus.SPI_MISO = cur_slave[7 - ph / 2];
    endtask

    // Run one full frame from just after a boundary; program the following frame meanwhile.
    task automatic frame(input logic en_early, input logic en_next, input logic [7:0] tx_next,
                         input bit loop_next, input logic [7:0] slave_next);
        int   pulses0;
        bit   idle_bad;
        logic [7:0] exp_rx;
        idle_bad = 0;
        if (cur_en) for (int b = 0; b < 8; b++) mosi_sb.push_back(cur_tx[7 - b]);
        exp_rx = !cur_en ? 8'hFF : (cur_loop ? cur_tx : cur_slave);
        rx_sb.push_back(exp_rx);
        pulses0 = sck_pulses;
        bus.SPI_Enable = en_early;
        bus.OutputData = tx_next;
        drive_miso(0);
        for (int i = 1; i <= 16; i++) begin
            step();
            if (i == 5) bus.SPI_Enable = en_next;
            if (!cur_en && i < 16 && (bus.SPI_CLK !== 1'b0 || bus.SPI_MOSI !== 1'b1)) idle_bad = 1;
            if (i < 16 && (i % 2) == 0) drive_miso(i);
        end
        checks++;
        if ((sck_pulses - pulses0) != (cur_en ? 8 : 0)) begin
            errors++;
            $display("FAIL sck_count got=%0d exp=%0d", sck_pulses - pulses0, cur_en ? 8 : 0);
        end
        if (!cur_en) begin
            checks++;
            if (idle_bad) begin
                errors++;
                $display("FAIL idle_lines got=activity exp=SCK0/MOSI1");
            end
        end
        cur_en    = en_next;
        cur_tx    = tx_next;
        cur_loop  = loop_next;
        cur_slave = slave_next;
    endtask

    task automatic check_reset_outputs(input string tag);
        checks++;
        if (bus.SPI_CLK !== 1'b0 || bus.SPI_MOSI !== 1'b1 || bus.DataClk !== 1'b0 ||
            bus.InputData !== 8'hFF) begin
            errors++;
            $display("FAIL %s got=sck%b mosi%b dclk%b in%h exp=sck0 mosi1 dclk0 inFF", tag,
                     bus.SPI_CLK, bus.SPI_MOSI, bus.DataClk, bus.InputData);
        end
    endtask

    task automatic release_reset();
        rst = 1'b0;
        edge_cnt = 0;
        prev_sck = 1'b0;
        prev_dclk = 1'b0;
        prev_mosi = 1'b1;
        cur_en = 1'b0;
        cur_tx = 8'hFF;
        mosi_sb.delete();
        rx_sb.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.SPI_Enable = 1'b0;
        bus.OutputData = 8'h00;
        bus.SPI_MISO = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_reset_outputs("reset_values");
        release_reset();
        // 64 idle clocks: DataClk rises at 16/32/48/64, lines stay idle, InputData all-ones.
        for (int f = 0; f < 4; f++) frame(1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
        checks++;
        if (bus.InputData !== 8'hFF) begin
            errors++;
            $display("FAIL idle_input_data got=%h exp=ff", bus.InputData);
        end
    endtask

    task automatic test_transfers();
        frame(1'b1, 1'b1, 8'h40, 1'b0, 8'h3C);  // idle, programs 0x40
        frame(1'b1, 1'b1, 8'hA5, 1'b1, 8'h00);  // sends 0x40, slave returns 0x3C
        frame(1'b1, 1'b1, 8'h5A, 1'b0, 8'h01);  // 0xA5 in loopback
        frame(1'b1, 1'b1, 8'h00, 1'b0, 8'h81);  // 0x5A out, slave 0x01 in
        frame(1'b1, 1'b1, 8'h95, 1'b0, 8'h7E);  // 0x95 written on the rise that delivers 0x01
    endtask

    task automatic test_enable_drop();
        frame(1'b1, 1'b0, 8'hFF, 1'b0, 8'h00);  // 0x95 completes despite drop at phase 5
        frame(1'b0, 1'b0, 8'h00, 1'b0, 8'h00);  // idle, yields 0xFF
    endtask

    task automatic test_reset_mid();
        frame(1'b1, 1'b1, 8'h0F, 1'b0, 8'hF0);  // idle, arms an enabled frame
        for (int b = 0; b < 8; b++) mosi_sb.push_back(cur_tx[7 - b]);
        drive_miso(0);
        for (int i = 1; i <= 9; i++) begin
            step();
            if ((i % 2) == 0) drive_miso(i);
        end
        rst = 1'b1;
        bus.SPI_Enable = 1'b1;
        @(negedge clk);
        check_reset_outputs("reset_midframe");
        release_reset();
        frame(1'b1, 1'b1, 8'hC6, 1'b1, 8'h00);  // first frame idle even with Enable high
        frame(1'b0, 1'b0, 8'h00, 1'b0, 8'h00);  // 0xC6 loopback
        frame(1'b0, 1'b0, 8'h00, 1'b0, 8'h00);  // idle
        checks++;
        if (mosi_sb.size() != 0 || rx_sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got=%0d/%0d exp=0/0", mosi_sb.size(), rx_sb.size());
        end
    endtask

    initial begin
        test_reset();
        test_transfers();
        test_enable_drop();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/full_spi.md
FULL_SPI -- requirements
Module: full_spi

Interface
REQ-001 Parameter IDLE_MOSI, default 1'b1: level driven on SPI_MOSI when no frame is active.
REQ-002 SPI_InputCLK  input  1  sole clock; all state updates on its rising edge.
REQ-003 Reset  input  1  reset, synchronous, active-high.
REQ-004 SPI_Enable  input  1  request to run SPI frames; sampled only at frame boundaries.
REQ-005 OutputData  input  8  byte to transmit, MSB first.
REQ-006 SPI_MISO  input  1  serial data from slave.
REQ-007 SPI_MOSI  output  1  serial data to slave, registered.
REQ-008 SPI_CLK  output  1  SPI serial clock (mode 0, CPOL=0/CPHA=0), registered.
REQ-009 InputData  output  8  last received byte, registered.
REQ-010 DataClk  output  1  byte-rate strobe clock, registered, period 16 SPI_InputCLK cycles.

Function
REQ-011 The block SHALL contain a 4-bit phase counter p incrementing by 1 every clock, wrapping 15->0; one frame = 16 clocks = 8 bits.
REQ-012 Bit b (b=0..7, b=0 is MSB) SHALL occupy phases 2b (SCK low) and 2b+1 (SCK high).
REQ-013 On the edge where p goes 15->0 the block SHALL: load tx shift register from OutputData; latch frame_en <= SPI_Enable; update InputData; set DataClk=1.
REQ-014 On the edge where p goes 7->8 the block SHALL set DataClk=0 (50% duty, high for phases 0-7).
REQ-015 OutputData SHALL be captured only at the 15->0 edge; a value written by user logic on a DataClk rising edge is transmitted in the next frame (one-frame latency).
REQ-016 When frame_en=1: SPI_CLK SHALL equal p[0] for the phase being entered; SPI_MOSI SHALL present tx bit 7-b from the edge entering phase 2b and hold through 2b+1.
REQ-017 When frame_en=1, on each edge entering an odd phase (SCK rising) the block SHALL shift SPI_MISO into rx LSB ({rx[6:0],MISO}).
REQ-018 At the 15->0 edge InputData SHALL receive rx (the 8 bits sampled in the ending frame) if that frame had frame_en=1, else 8'hFF.
REQ-019 When frame_en=0: SPI_CLK SHALL be 0, SPI_MOSI SHALL be IDLE_MOSI, MISO ignored; p and DataClk keep running.
REQ-020 SPI_Enable changes mid-frame SHALL have no effect until the next 15->0 edge; no partial frames are ever emitted.
REQ-021 OutputData changes mid-frame SHALL not affect the frame in progress.
REQ-022 SPI_CLK SHALL be low at every frame boundary, so consecutive enabled frames give exactly 8 SCK pulses each with no glitch.

Reset
REQ-023 While Reset=1 at a clock edge: p=0, frame_en=0, DataClk=0, SPI_CLK=0, SPI_MOSI=IDLE_MOSI, InputData=8'hFF, tx=8'hFF, rx=8'hFF.
REQ-024 Reset SHALL take priority over all other updates, including mid-frame; the aborted frame produces no InputData update.
REQ-025 After Reset deasserts, the first DataClk rise SHALL occur on the 16th clock edge (first 15->0 transition); the first frame is idle regardless of SPI_Enable.

Verification
REQ-026 Reset, SPI_Enable=0 for 64 clocks -> SPI_CLK stays 0, SPI_MOSI=1, DataClk toggles with period 16 (rises at edges 16,32,48,64), InputData=8'hFF.
REQ-027 SPI_Enable=1, OutputData=8'h40 held before a boundary -> next frame: 8 SCK pulses, MOSI sequence 0,1,0,0,0,0,0,0 stable across each SCK rise.
REQ-028 Loopback MISO=MOSI, OutputData=8'hA5 -> InputData=8'hA5 at the DataClk rise ending that frame.
REQ-029 Slave drives 8'h01 on MISO (changing on SCK falling) -> InputData=8'h01 after the frame; OutputData updated on that DataClk rise (8'h95) appears on MOSI one frame later.
REQ-030 Drop SPI_Enable at phase 5 -> current frame completes all 8 SCK pulses; following frame idle, InputData=8'hFF after it.
REQ-031 Assert Reset at phase 9 of an enabled frame -> next edge all outputs at reset values; InputData unchanged from 8'hFF, first DataClk rise 16 edges after release.
